// File: rtl/mapu_out_serializer.sv
// mapu_out_serializer: buffers 4-element matrix rows from the APU in a small
// row FIFO and replays each 4x4 matrix as a row-major element stream with
// start/end-of-matrix markers and a per-matrix overflow flag.
module mapu_out_serializer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_vld,
    output logic              o_rdy,
    input  logic [DATA_W-1:0] i_r0,
    input  logic [DATA_W-1:0] i_r1,
    input  logic [DATA_W-1:0] i_r2,
    input  logic [DATA_W-1:0] i_r3,
    input  logic              i_of,
    output logic              o_vld,
    input  logic              i_rdy,
    output logic [DATA_W-1:0] o_data,
    output logic              o_sop,
    output logic              o_eop,
    output logic              o_of
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    // One buffered row: four elements (column 0 in the low lane) plus its overflow bit.
    typedef struct packed {
        logic [3:0][DATA_W-1:0] el;
        logic                   of;
    } row_t;

    row_t          mem [DEPTH];
    row_t          head;
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   cnt, cnt_nxt;
    logic [1:0]    col, rrow;
    logic          of_acc;
    logic          rdy_q;
    logic          push, xfer, pop;

    // o_rdy is a register, so accepting a row never depends on i_rdy this cycle.
    assign o_rdy = rdy_q;
    assign push  = i_vld && rdy_q;
    assign o_vld = (cnt != '0);
    assign xfer  = o_vld && i_rdy;
    assign pop   = xfer && (col == 2'd3);
    assign head  = mem[rptr];

    // Element view of the head row; framing comes purely from the read-side counters.
    assign o_data = o_vld ? head.el[col] : '0;
    assign o_sop  = o_vld && (rrow == 2'd0) && (col == 2'd0);
    assign o_eop  = o_vld && (rrow == 2'd3) && (col == 2'd3);
    assign o_of   = o_eop && (of_acc || head.of);

    // Next occupancy: simultaneous push and pop cancel out.
    always_comb begin
        cnt_nxt = cnt;
        if (push && !pop)
            cnt_nxt = cnt + (AW+1)'(1);
        else if (pop && !push)
            cnt_nxt = cnt - (AW+1)'(1);
    end

    // Row storage; contents are don't-care until written, reads are masked by o_vld.
    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= '{el: {i_r3, i_r2, i_r1, i_r0}, of: i_of};
    end

    // FIFO pointers, occupancy and the registered ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            cnt   <= '0;
            rdy_q <= 1'b0;
        end else begin
            if (push)
                wptr <= wptr + AW'(1);
            if (pop)
                rptr <= rptr + AW'(1);
            cnt   <= cnt_nxt;
            rdy_q <= (cnt_nxt < FULL);
        end
    end

    // Column / matrix-row framing and sticky overflow of rows 0..2.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col    <= '0;
            rrow   <= '0;
            of_acc <= 1'b0;
        end else if (xfer) begin
            col <= col + 2'd1;
            if (pop) begin
                rrow   <= rrow + 2'd1;
                of_acc <= (rrow == 2'd3) ? 1'b0 : (of_acc || head.of);
            end
        end
    end

endmodule

// File: tb/tb_mapu_out_serializer.sv
// Scoreboard bench for mapu_out_serializer: stimulus queues rows and the
// expected element beats at matrix level; a monitor checks every output beat.
module tb_mapu_out_serializer;

    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          i_vld = 1'b0, i_rdy = 1'b0, i_of = 1'b0;
    logic [DW-1:0] i_r0 = '0, i_r1 = '0, i_r2 = '0, i_r3 = '0;
    logic          o_rdy, o_vld, o_sop, o_eop, o_of;
    logic [DW-1:0] o_data;

    mapu_out_serializer #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .i_vld(i_vld), .o_rdy(o_rdy),
        .i_r0(i_r0), .i_r1(i_r1), .i_r2(i_r2), .i_r3(i_r3), .i_of(i_of),
        .o_vld(o_vld), .i_rdy(i_rdy), .o_data(o_data),
        .o_sop(o_sop), .o_eop(o_eop), .o_of(o_of)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0][DW-1:0] el;
        logic               of;
    } row_s;
    typedef struct packed {
        logic [DW-1:0] d;
        logic          sop, eop, of, lastcol;
    } beat_s;
    typedef logic [DW-1:0] mat_t [16];

    row_s  rows_q[$];
    beat_s exp_q[$];
    int    checks = 0, errors = 0;
    int    n_sop = 0, n_eop = 0, n_acc = 0;
    int    vld_pct = 0, rdy_pct = 0;
    int    sop0, eop0;
    mat_t  m;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Queue the 4 rows and the 16 expected beats of one matrix.
    task automatic add_matrix(input mat_t mm, input logic [3:0] ofs);
        row_s  rw;
        beat_s b;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) rw.el[c] = mm[4*r+c];
            rw.of = ofs[r];
            rows_q.push_back(rw);
        end
        for (int e = 0; e < 16; e++) begin
            b.d       = mm[e];
            b.sop     = (e == 0);
            b.eop     = (e == 15);
            b.of      = (e == 15) && (ofs != 4'b0);
            b.lastcol = ((e % 4) == 3);
            exp_q.push_back(b);
        end
    endtask

    task automatic drive();
        i_vld = (rows_q.size() > 0) && (int'($urandom_range(99)) < vld_pct);
        i_rdy = (int'($urandom_range(99)) < rdy_pct);
        if (rows_q.size() > 0) begin
            {i_r3, i_r2, i_r1, i_r0} = rows_q[0].el;
            i_of = rows_q[0].of;
        end
    endtask

    task automatic cyc();
        bit acc;
        @(negedge clk);
        acc = i_vld && o_rdy;
        @(posedge clk);
        #1;
        if (acc) begin
            void'(rows_q.pop_front());
            n_acc++;
        end
        drive();
    endtask

    task automatic drain(input int bound);
        int t = 0;
        while ((exp_q.size() > 0 || rows_q.size() > 0) && t < bound) begin
            cyc();
            t++;
        end
        chk("drain_left", 64'(exp_q.size()), 64'(0));
    endtask

    // Monitor: outputs sampled on the falling edge, ahead of the next transfer edge.
    int         occ = 0;
    bit         live = 0, held = 0, psh, pp;
    logic [DW-1:0] hd;
    logic [2:0]    hflags;

    always @(negedge clk) begin
        if (reset) begin
            chk("rst_o_rdy", 64'(o_rdy), 64'(0));
            chk("rst_o_vld", 64'(o_vld), 64'(0));
            chk("rst_o_data", 64'(o_data), 64'(0));
            chk("rst_flags", 64'({o_sop, o_eop, o_of}), 64'(0));
            occ  = 0;
            live = 0;
            held = 0;
        end else begin
            pp  = 0;
            psh = i_vld && o_rdy;
            if (live) chk("o_rdy_vs_occ", 64'(o_rdy), 64'(occ < DEPTH));
            chk("o_vld_vs_occ", 64'(o_vld), 64'(occ > 0));
            if (held) begin
                chk("stall_vld", 64'(o_vld), 64'(1));
                chk("stall_data", 64'(o_data), 64'(hd));
                chk("stall_flags", 64'({o_sop, o_eop, o_of}), 64'(hflags));
            end
            if (o_vld) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 64'(o_vld), 64'(0));
                end else begin
                    chk("data", 64'(o_data), 64'(exp_q[0].d));
                    chk("sop", 64'(o_sop), 64'(exp_q[0].sop));
                    chk("eop", 64'(o_eop), 64'(exp_q[0].eop));
                    chk("of", 64'(o_of), 64'(exp_q[0].of));
                    if (i_rdy) begin
                        pp = exp_q[0].lastcol;
                        if (o_sop) n_sop++;
                        if (o_eop) n_eop++;
                        void'(exp_q.pop_front());
                    end
                end
            end else begin
                chk("idle_flags", 64'({o_sop, o_eop, o_of}), 64'(0));
            end
            held   = o_vld && !i_rdy;
            hd     = o_data;
            hflags = {o_sop, o_eop, o_of};
            occ    = occ + int'(psh) - int'(pp);
            live   = 1;
        end
    end

    initial begin
        // Reset and ready release
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rdy_before_edge", 64'(o_rdy), 64'(0));
        @(posedge clk);
        #1;
        chk("rdy_after_edge", 64'(o_rdy), 64'(1));

        // Single matrix 0x00..0x0F, no backpressure
        for (int e = 0; e < 16; e++) m[e] = DW'(e);
        add_matrix(m, 4'b0000);
        vld_pct = 100; rdy_pct = 100;
        drive();
        chk("vld_before_push", 64'(o_vld), 64'(0));
        cyc();
        chk("first_beat_latency", 64'(o_vld), 64'(1));
        drain(2000);

        // Backpressure fill, then pop at full with a push pending
        for (int e = 0; e < 16; e++) m[e] = DW'(32'h100 + e);
        add_matrix(m, 4'b0000);
        for (int e = 0; e < 16; e++) m[e] = DW'(32'h200 + e);
        add_matrix(m, 4'b0000);
        vld_pct = 100; rdy_pct = 0;
        drive();
        n_acc = 0;
        repeat (10) cyc();
        chk("fill_rows", 64'(n_acc), 64'(DEPTH));
        chk("full_rdy", 64'(o_rdy), 64'(0));
        rdy_pct = 100;
        drive();
        repeat (4) cyc();
        chk("no_push_on_pop", 64'(n_acc), 64'(DEPTH));
        chk("rdy_after_pop", 64'(o_rdy), 64'(1));
        rdy_pct = 0;
        drive();
        cyc();
        chk("push_after_pop", 64'(n_acc), 64'(DEPTH + 1));
        chk("full_again", 64'(o_rdy), 64'(0));
        rdy_pct = 100;
        drive();
        drain(2000);

        // Overflow framing: A has overflow on row 1 only, B is clean
        for (int e = 0; e < 16; e++) m[e] = $urandom;
        add_matrix(m, 4'b0010);
        for (int e = 0; e < 16; e++) m[e] = $urandom;
        add_matrix(m, 4'b0000);
        vld_pct = 100; rdy_pct = 100;
        drive();
        drain(2000);

        // Reset mid-matrix: 2 rows in, 3 elements out
        for (int e = 0; e < 16; e++) m[e] = DW'(32'h300 + e);
        add_matrix(m, 4'b1111);
        vld_pct = 100; rdy_pct = 0;
        drive();
        repeat (2) cyc();
        vld_pct = 0; rdy_pct = 100;
        drive();
        repeat (3) cyc();
        reset = 1'b1;
        rows_q.delete();
        exp_q.delete();
        vld_pct = 0; rdy_pct = 0;
        drive();
        repeat (3) cyc();
        reset = 1'b0;
        chk("rst_rdy_low", 64'(o_rdy), 64'(0));
        cyc();
        chk("rst_rdy_high", 64'(o_rdy), 64'(1));
        for (int e = 0; e < 16; e++) m[e] = DW'(32'h400 + e);
        add_matrix(m, 4'b0000);
        vld_pct = 100; rdy_pct = 100;
        drive();
        drain(2000);

        // Random stalls over 100 matrices
        sop0 = n_sop;
        eop0 = n_eop;
        for (int k = 0; k < 100; k++) begin
            logic [3:0] ofs;
            for (int e = 0; e < 16; e++) m[e] = $urandom;
            for (int r = 0; r < 4; r++) ofs[r] = ($urandom_range(7) == 0);
            add_matrix(m, ofs);
        end
        vld_pct = 50; rdy_pct = 50;
        drive();
        drain(40000);
        chk("sop_count", 64'(n_sop - sop0), 64'(100));
        chk("eop_count", 64'(n_eop - eop0), 64'(100));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
